// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, runs the imem req/gnt/rvalid
// handshake, buffers fetched words in an in-order skid FIFO and applies redirects.
//
// state  | meaning
// S_IDLE | no request; waits until outstanding + buffered < FIFO_DEPTH
// S_REQ  | request asserted, address held stable until granted
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [6:0]  opcode_o
);
  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic {S_IDLE, S_REQ} state_t;
  state_t r_state, w_state_nxt;

  logic [31:0]   r_pc, w_pc_nxt, r_stale_addr;
  logic          r_stale, w_stale_nxt;
  logic [CW-1:0] r_out, r_drop, r_cnt;
  logic [CW-1:0] w_out_nxt, w_drop_nxt, w_cnt_nxt, w_ifq_wr, w_fifo_wr;
  logic [CW:0]   w_slots_nxt;
  logic [31:0]   r_ifq [FIFO_DEPTH];
  logic [31:0]   w_ifq_nxt [FIFO_DEPTH];
  logic [31:0]   r_fdata [FIFO_DEPTH];
  logic [31:0]   r_faddr [FIFO_DEPTH];
  logic [31:0]   w_fdata_nxt [FIFO_DEPTH];
  logic [31:0]   w_faddr_nxt [FIFO_DEPTH];
  logic          w_gnt, w_pop, w_push, w_drop_rsp;
  logic [31:0]   w_addr, w_redirect_pc;

  // A request left ungranted across a redirect keeps its old address in r_stale_addr
  assign imem_req_o    = (r_state == S_REQ);
  assign w_gnt         = imem_req_o & imem_gnt_i;
  assign w_addr        = r_stale ? r_stale_addr : r_pc;
  assign imem_addr_o   = w_addr;
  assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;

  assign instr_valid_o = (r_cnt != '0);
  assign instr_o       = instr_valid_o ? r_fdata[0] : NOP;
  assign instr_pc_o    = instr_valid_o ? r_faddr[0] : '0;
  assign opcode_o      = instr_o[6:0];

  assign w_pop       = instr_valid_o & ~stall_i;
  assign w_drop_rsp  = imem_rvalid_i & (r_drop != '0);
  assign w_push      = imem_rvalid_i & (r_drop == '0) & ~redirect_i;
  assign w_out_nxt   = r_out + CW'(w_gnt) - CW'(imem_rvalid_i);
  assign w_cnt_nxt   = redirect_i ? '0 : (r_cnt - CW'(w_pop) + CW'(w_push));
  assign w_slots_nxt = {1'b0, w_out_nxt} + {1'b0, w_cnt_nxt};
  assign w_ifq_wr    = r_out - CW'(imem_rvalid_i);
  assign w_fifo_wr   = r_cnt - CW'(w_pop);

  // Everything still in flight after a redirect is wrong-path, so drop = outstanding
  always_comb begin
    w_pc_nxt    = r_pc;
    w_stale_nxt = r_stale;
    w_drop_nxt  = r_drop;
    if (redirect_i) begin
      w_pc_nxt   = w_redirect_pc;
      w_drop_nxt = w_out_nxt;
    end else begin
      if (w_gnt && !r_stale) w_pc_nxt = r_pc + 32'd4;
      w_drop_nxt = r_drop - CW'(w_drop_rsp) + CW'(w_gnt & r_stale);
    end
    if (w_gnt) w_stale_nxt = 1'b0;
    else if (redirect_i && imem_req_o) w_stale_nxt = 1'b1;
  end

  always_comb begin
    w_ifq_nxt = r_ifq;
    if (imem_rvalid_i)
      for (int i = 0; i < FIFO_DEPTH - 1; i++) w_ifq_nxt[i] = r_ifq[i + 1];
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (w_gnt && (CW'(i) == w_ifq_wr)) w_ifq_nxt[i] = w_addr;
  end

  always_comb begin
    w_fdata_nxt = r_fdata;
    w_faddr_nxt = r_faddr;
    if (w_pop)
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        w_fdata_nxt[i] = r_fdata[i + 1];
        w_faddr_nxt[i] = r_faddr[i + 1];
      end
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (w_push && (CW'(i) == w_fifo_wr)) begin
        w_fdata_nxt[i] = imem_rdata_i;
        w_faddr_nxt[i] = r_ifq[0];
      end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_slots_nxt < DEPTH_W) w_state_nxt = S_REQ;
      S_REQ:   if (imem_gnt_i) w_state_nxt = (w_slots_nxt < DEPTH_W) ? S_REQ : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_stale      <= 1'b0;
      r_stale_addr <= RESET_PC;
      r_out        <= '0;
      r_drop       <= '0;
      r_cnt        <= '0;
      r_ifq        <= '{default: '0};
      r_fdata      <= '{default: '0};
      r_faddr      <= '{default: '0};
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_stale <= w_stale_nxt;
      r_out   <= w_out_nxt;
      r_drop  <= w_drop_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ifq   <= w_ifq_nxt;
      r_fdata <= w_fdata_nxt;
      r_faddr <= w_faddr_nxt;
      if (redirect_i && imem_req_o && !imem_gnt_i) r_stale_addr <= w_addr;
    end
  end

  a_rvalid_needs_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni) imem_rvalid_i |-> (r_out != '0));

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end instruction fetch stage; supplies the instruction word, and hence the 7-bit opcode, that the main decoder consumes.
- Owns the fetch PC and runs the request/grant/response handshake to instruction memory.
- Buffers up to two fetched words in an in-order skid FIFO.
- Applies branch/jump redirects from execute, discarding wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
FIFO_DEPTH, 2, instruction buffer entries; also the max in-flight plus buffered total (fixed at 2 for this revision)

Ports:
clk_i  input  1  single clock, rising edge
rst_ni  input  1  asynchronous active-low reset
imem_req_o  output  1  fetch request to instruction memory
imem_addr_o  output  32  fetch address, word aligned
imem_gnt_i  input  1  request accepted this cycle (req && gnt = handshake)
imem_rvalid_i  input  1  response data valid; responses return in request order
imem_rdata_i  input  32  response instruction word
redirect_i  input  1  taken branch/jump from execute
redirect_pc_i  input  32  redirect target
stall_i  input  1  downstream not accepting (decode stalled)
instr_valid_o  output  1  instr_o/instr_pc_o valid
instr_o  output  32  instruction word (NOP 32'h0000_0013 when not valid)
instr_pc_o  output  32  PC of instr_o
opcode_o  output  7  instr_o[6:0], feeds decoder opcode input

Behaviour:
- Clock/reset: one clock, clk_i. Reset is asynchronous and active-low (rst_ni); all state clears immediately on assertion.
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=32'h0000_0013, opcode_o=7'h13, instr_pc_o=0. Internal: pc_q=RESET_PC, FIFO empty, outstanding=0, drop=0, FSM=IDLE.
- FSM states:
  - IDLE: imem_req_o=0. Go to REQ when slots = outstanding + fifo_count < 2.
  - REQ: imem_req_o=1 and imem_addr_o=pc_q, both held stable until imem_gnt_i. Address must not change while ungranted, even across a redirect.
  - On grant: push pc_q into the in-flight address queue, outstanding++, pc_q += 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - After grant: stay in REQ if slots (after update) < 2, else go to IDLE. Back-to-back grants are allowed, so steady state is one request per cycle.
- Response: on imem_rvalid_i, pop the in-flight address queue and decrement outstanding.
  - If drop > 0: discard the word, drop--.
  - Else: push {rdata, addr} into the FIFO.
  - Slot accounting guarantees the FIFO never overflows. An rvalid with outstanding==0 is a protocol error (assertion).
- Output: FIFO head is presented registered. Min latency: grant at cycle t, rvalid at t+1, instr_valid_o at t+2.
  - Head pops when instr_valid_o && !stall_i.
  - Push and pop in the same cycle are allowed.
  - With stall_i=1, outputs hold stable.
- Redirect (priority over stall and rvalid-push):
  - FIFO flushed; instr_valid_o=0 the next cycle.
  - drop set to in-flight requests not yet responded after this cycle. This includes a request granted in the redirect cycle, and excludes an rvalid arriving in the redirect cycle (that word is discarded).
  - A request pending ungranted at redirect keeps its old address; when granted it is counted into drop.
  - pc_q <= {redirect_pc_i[31:2], 2'b00}. Its first request issues once the old pending request is granted, or in the next cycle if none is pending.
  - A back-to-back redirect overrides the previous target; drop accumulates correctly.
- Reset mid-operation: all in-flight state is lost. Memory is expected to be reset by the same rst_ni.

Test Plan:
- Basic stream: reset release, gnt=1, rvalid one cycle after grant, stall=0 -> addrs 0,4,8,...; instr_valid_o first high 2 cycles after the first grant; instr_pc_o 0,4,8 with matching words; opcode_o=instr_o[6:0].
- Back-pressure: stall_i=1 for 5 cycles mid-stream -> at most 2 outstanding+buffered; imem_req_o drops; output held; no word lost or duplicated after release.
- Redirect with 2 in flight: redirect_pc_i=32'h0000_0103 -> both stale responses discarded; next valid instr_pc_o=32'h0000_0100.
- Redirect while req ungranted (gnt=0 for 3 cycles): imem_addr_o stays at the old addr until gnt; its response is dropped; next issued addr = target.
- Wrap-around: RESET_PC=32'hFFFF_FFF8 -> addrs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset mid-stream with 2 outstanding -> outputs return to reset values immediately; after release, fetch restarts at RESET_PC.
